// File: rtl/op_decoder.sv
// op_decoder
//   Receive side of the 40-bit op-packet link. Takes pre-sampled serial bits
//   from the line sampler, one strobe per bit. Frame format is a start bit (0),
//   40 data bits MSB first, then a stop bit (1). The op byte [39:32] of each
//   good frame is decoded into an audio-sample, keyboard-poll or
//   control-register action. Decode results appear one clock after the
//   stop-bit strobe.
//
// Ports
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous reset, active-low
//   in_bit        in   1   sampled line bit, qualified by in_bit_valid
//   in_bit_valid  in   1   one-cycle strobe per received bit
//   audio_valid   out  1   pulse: op 8'hC7 decoded
//   audio_data    out  32  packet[31:0] of the last C7 packet
//   kbd_poll      out  1   pulse: op 8'hC5 decoded
//   ctrl_reg      out  8   packet[31:24] of the last C4 packet
//   unknown_op    out  1   pulse: good frame carrying any other op byte
//   frame_error   out  1   pulse: bad stop bit or inter-bit timeout
//   busy          out  1   high while a frame is in progress
//   err_count     out  8   saturating count of frame_error/unknown_op pulses
//
// Build option
//   OPDEC_ERRCNT_EN : when defined, adds the err_count port and its counter.
//
// States
//   ST_IDLE | waiting for a start bit (strobe with in_bit == 0)
//   ST_DATA | shifting in the 40 data bits
//   ST_STOP | waiting for the stop-bit strobe, then decode or flag error

module op_decoder #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TIMEOUT_W      = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_bit,
    input  logic        in_bit_valid,
    output logic        audio_valid,
    output logic [31:0] audio_data,
    output logic        kbd_poll,
    output logic [7:0]  ctrl_reg,
    output logic        unknown_op,
    output logic        frame_error,
    output logic        busy
`ifdef OPDEC_ERRCNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [5:0]           LAST_BIT      = 6'd39;

    localparam logic [7:0] OP_AUDIO = 8'hC7;
    localparam logic [7:0] OP_KBD   = 8'hC5;
    localparam logic [7:0] OP_CTRL  = 8'hC4;

    state_t                 state_q,       state_d;
    logic [39:0]            shift_q,       shift_d;
    logic [5:0]             bit_cnt_q,     bit_cnt_d;
    logic [TIMEOUT_W-1:0]   gap_q,         gap_d;
    logic                   audio_valid_q, audio_valid_d;
    logic [31:0]            audio_data_q,  audio_data_d;
    logic                   kbd_poll_q,    kbd_poll_d;
    logic [7:0]             ctrl_reg_q,    ctrl_reg_d;
    logic                   unknown_op_q,  unknown_op_d;
    logic                   frame_error_q, frame_error_d;
    logic                   busy_q,        busy_d;
    logic [TIMEOUT_W-1:0]   gap_next;
    logic                   gap_expired;
`ifdef OPDEC_ERRCNT_EN
    logic [7:0]             err_count_q,   err_count_d;
`endif

    // The gap counter only advances on cycles without a strobe, so a strobe
    // landing on the cycle that would reach the limit always wins.
    assign gap_next    = gap_q + TIMEOUT_W'(1);
    assign gap_expired = (gap_next == TIMEOUT_LIMIT);

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        gap_d         = gap_q;
        audio_data_d  = audio_data_q;
        ctrl_reg_d    = ctrl_reg_q;
        audio_valid_d = 1'b0;
        kbd_poll_d    = 1'b0;
        unknown_op_d  = 1'b0;
        frame_error_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_bit_valid && !in_bit) begin
                    state_d   = ST_DATA;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    gap_d     = '0;
                end
            end

            ST_DATA: begin
                if (in_bit_valid) begin
                    shift_d   = {shift_q[38:0], in_bit};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    gap_d     = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end
                end else if (gap_expired) begin
                    state_d       = ST_IDLE;
                    frame_error_d = 1'b1;
                    bit_cnt_d     = '0;
                    gap_d         = '0;
                end else begin
                    gap_d = gap_next;
                end
            end

            ST_STOP: begin
                if (in_bit_valid) begin
                    // A 0 here is a broken stop bit, never a new start bit.
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    gap_d     = '0;
                    if (in_bit) begin
                        case (shift_q[39:32])
                            OP_AUDIO: begin
                                audio_data_d  = shift_q[31:0];
                                audio_valid_d = 1'b1;
                            end
                            OP_KBD: begin
                                kbd_poll_d = 1'b1;
                            end
                            OP_CTRL: begin
                                ctrl_reg_d = shift_q[31:24];
                            end
                            default: begin
                                unknown_op_d = 1'b1;
                            end
                        endcase
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else if (gap_expired) begin
                    state_d       = ST_IDLE;
                    frame_error_d = 1'b1;
                    bit_cnt_d     = '0;
                    gap_d         = '0;
                end else begin
                    gap_d = gap_next;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                gap_d     = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

`ifdef OPDEC_ERRCNT_EN
    always_comb begin
        err_count_d = err_count_q;
        if ((frame_error_d || unknown_op_d) && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            gap_q         <= '0;
            audio_valid_q <= 1'b0;
            audio_data_q  <= '0;
            kbd_poll_q    <= 1'b0;
            ctrl_reg_q    <= '0;
            unknown_op_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
`ifdef OPDEC_ERRCNT_EN
            err_count_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            gap_q         <= gap_d;
            audio_valid_q <= audio_valid_d;
            audio_data_q  <= audio_data_d;
            kbd_poll_q    <= kbd_poll_d;
            ctrl_reg_q    <= ctrl_reg_d;
            unknown_op_q  <= unknown_op_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
`ifdef OPDEC_ERRCNT_EN
            err_count_q   <= err_count_d;
`endif
        end
    end

    assign audio_valid = audio_valid_q;
    assign audio_data  = audio_data_q;
    assign kbd_poll    = kbd_poll_q;
    assign ctrl_reg    = ctrl_reg_q;
    assign unknown_op  = unknown_op_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;
`ifdef OPDEC_ERRCNT_EN
    assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_op_decoder.sv
// tb_op_decoder
//   Directed bench for op_decoder. Bits are strobed on consecutive cycles,
//   inputs change on the falling edge and outputs are read on the falling edge.
//   A falling-edge monitor counts every pulse so that tests can also check
//   that no unexpected pulse appeared.

module tb_op_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_bit;
    logic        in_bit_valid;
    logic        audio_valid;
    logic [31:0] audio_data;
    logic        kbd_poll;
    logic [7:0]  ctrl_reg;
    logic        unknown_op;
    logic        frame_error;
    logic        busy;
`ifdef OPDEC_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int n_audio  = 0;
    int n_kbd    = 0;
    int n_unk    = 0;
    int n_ferr   = 0;

    op_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_bit       (in_bit),
        .in_bit_valid (in_bit_valid),
        .audio_valid  (audio_valid),
        .audio_data   (audio_data),
        .kbd_poll     (kbd_poll),
        .ctrl_reg     (ctrl_reg),
        .unknown_op   (unknown_op),
        .frame_error  (frame_error),
        .busy         (busy)
`ifdef OPDEC_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (audio_valid === 1'b1) n_audio++;
        if (kbd_poll    === 1'b1) n_kbd++;
        if (unknown_op  === 1'b1) n_unk++;
        if (frame_error === 1'b1) n_ferr++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        in_bit       = b;
        in_bit_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [39:0] pkt, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 39; i >= 0; i--) send_bit(pkt[i]);
        send_bit(stop_bit);
    endtask

    task automatic idle(input int n);
        in_bit_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        in_bit       = 1'b0;
        in_bit_valid = 1'b0;
        #1;
        n_checks++;
        if ({audio_valid, kbd_poll, unknown_op, frame_error, busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {audio_valid, kbd_poll, unknown_op, frame_error, busy});
        end
        n_checks++;
        if ({audio_data, ctrl_reg} !== 40'h0) begin
            n_errors++;
            $display("FAIL reset_regs got %h exp 0000000000", {audio_data, ctrl_reg});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_audio();
        int s_audio, s_ferr;
        s_audio = n_audio;
        s_ferr  = n_ferr;
        send_frame(40'hC7_12345678, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (audio_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL audio_pulse got %b exp 1", audio_valid);
        end
        n_checks++;
        if (audio_data !== 32'h12345678) begin
            n_errors++;
            $display("FAIL audio_data got %h exp 12345678", audio_data);
        end
        @(negedge clk);
        n_checks++;
        if (audio_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL audio_pulse_width got %b exp 0", audio_valid);
        end
        idle(2);
        #1;
        n_checks++;
        if ((n_audio - s_audio) !== 1 || (n_ferr - s_ferr) !== 0) begin
            n_errors++;
            $display("FAIL audio_counts got audio %0d ferr %0d exp 1 0",
                     n_audio - s_audio, n_ferr - s_ferr);
        end
    endtask

    task automatic test_ctrl_kbd();
        int s_any;
        s_any = n_audio + n_kbd + n_unk + n_ferr;
        send_frame(40'hC4_A5000000, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (ctrl_reg !== 8'hA5) begin
            n_errors++;
            $display("FAIL ctrl_reg got %h exp a5", ctrl_reg);
        end
        idle(2);
        #1;
        n_checks++;
        if ((n_audio + n_kbd + n_unk + n_ferr) !== s_any) begin
            n_errors++;
            $display("FAIL ctrl_no_pulse got %0d pulses exp 0",
                     n_audio + n_kbd + n_unk + n_ferr - s_any);
        end
        send_frame(40'hC5_00000000, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (kbd_poll !== 1'b1) begin
            n_errors++;
            $display("FAIL kbd_pulse got %b exp 1", kbd_poll);
        end
        @(negedge clk);
        n_checks++;
        if (kbd_poll !== 1'b0 || ctrl_reg !== 8'hA5) begin
            n_errors++;
            $display("FAIL kbd_after got kbd %b ctrl %h exp 0 a5", kbd_poll, ctrl_reg);
        end
        idle(2);
    endtask

    task automatic test_bad_stop();
        int s_audio;
        s_audio = n_audio;
        send_frame(40'hC7_DEADBEEF, 1'b0);
        in_bit_valid = 1'b0;
        n_checks++;
        if (frame_error !== 1'b1 || audio_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_stop got ferr %b audio %b busy %b exp 1 0 0",
                     frame_error, audio_valid, busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_error !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_stop_width got %b exp 0", frame_error);
        end
        idle(2);
        #1;
        n_checks++;
        if (audio_data !== 32'h12345678 || (n_audio - s_audio) !== 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_stop_hold got data %h audio %0d busy %b exp 12345678 0 0",
                     audio_data, n_audio - s_audio, busy);
        end
    endtask

    task automatic test_unknown();
        send_frame(40'h00_00000000, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (unknown_op !== 1'b1 || audio_valid !== 1'b0 || kbd_poll !== 1'b0) begin
            n_errors++;
            $display("FAIL unknown_pulse got unk %b audio %b kbd %b exp 1 0 0",
                     unknown_op, audio_valid, kbd_poll);
        end
        @(negedge clk);
        n_checks++;
        if (unknown_op !== 1'b0 || ctrl_reg !== 8'hA5) begin
            n_errors++;
            $display("FAIL unknown_after got unk %b ctrl %h exp 0 a5", unknown_op, ctrl_reg);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        int s_kbd, s_audio;
        s_kbd   = n_kbd;
        s_audio = n_audio;
        send_frame(40'hC5_11223344, 1'b1);
        send_frame(40'hC7_CAFEF00D, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (audio_valid !== 1'b1 || audio_data !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL b2b_audio got %b %h exp 1 cafef00d", audio_valid, audio_data);
        end
        idle(2);
        #1;
        n_checks++;
        if ((n_kbd - s_kbd) !== 1 || (n_audio - s_audio) !== 1) begin
            n_errors++;
            $display("FAIL b2b_counts got kbd %0d audio %0d exp 1 1",
                     n_kbd - s_kbd, n_audio - s_audio);
        end
    endtask

    task automatic test_timeout();
        send_bit(1'b0);
        for (int i = 0; i < 20; i++) send_bit(i[0]);
        in_bit_valid = 1'b0;
        repeat (1023) @(negedge clk);
        n_checks++;
        if (frame_error !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_early got ferr %b busy %b exp 0 1", frame_error, busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_error !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_fire got ferr %b busy %b exp 1 0", frame_error, busy);
        end
        @(negedge clk);
        n_checks++;
        if (frame_error !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_width got %b exp 0", frame_error);
        end
        idle(2);
        send_frame(40'hC7_0BADCAFE, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (audio_valid !== 1'b1 || audio_data !== 32'h0BADCAFE) begin
            n_errors++;
            $display("FAIL timeout_recover got %b %h exp 1 0badcafe", audio_valid, audio_data);
        end
        idle(2);
    endtask

    task automatic test_strobe_wins();
        logic [39:0] pkt;
        int          s_ferr;
        pkt    = 40'hC7_55AA1234;
        s_ferr = n_ferr;
        send_bit(1'b0);
        for (int i = 39; i >= 20; i--) send_bit(pkt[i]);
        in_bit_valid = 1'b0;
        repeat (1023) @(negedge clk);
        for (int i = 19; i >= 0; i--) send_bit(pkt[i]);
        send_bit(1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (audio_valid !== 1'b1 || audio_data !== 32'h55AA1234) begin
            n_errors++;
            $display("FAIL strobe_wins got %b %h exp 1 55aa1234", audio_valid, audio_data);
        end
        idle(2);
        #1;
        n_checks++;
        if ((n_ferr - s_ferr) !== 0) begin
            n_errors++;
            $display("FAIL strobe_wins_ferr got %0d exp 0", n_ferr - s_ferr);
        end
    endtask

    task automatic test_reset_mid();
        logic [39:0] pkt;
        int          s_any;
        pkt = 40'hC7_11111111;
        send_bit(1'b0);
        for (int i = 39; i >= 10; i--) send_bit(pkt[i]);
        rst_n        = 1'b0;
        in_bit_valid = 1'b0;
        #1;
        n_checks++;
        if ({audio_valid, kbd_poll, unknown_op, frame_error, busy} !== 5'b0 ||
            {audio_data, ctrl_reg} !== 40'h0) begin
            n_errors++;
            $display("FAIL reset_mid got flags %b regs %h exp 0 0",
                     {audio_valid, kbd_poll, unknown_op, frame_error, busy},
                     {audio_data, ctrl_reg});
        end
`ifdef OPDEC_ERRCNT_EN
        n_checks++;
        if (err_count !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_errcnt got %h exp 00", err_count);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        s_any = n_audio + n_kbd + n_unk + n_ferr;
        idle(5);
        #1;
        n_checks++;
        if ((n_audio + n_kbd + n_unk + n_ferr) !== s_any || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release got pulses %0d busy %b exp 0 0",
                     n_audio + n_kbd + n_unk + n_ferr - s_any, busy);
        end
        send_frame(40'hC4_3C000000, 1'b1);
        in_bit_valid = 1'b0;
        n_checks++;
        if (ctrl_reg !== 8'h3C) begin
            n_errors++;
            $display("FAIL reset_recover got %h exp 3c", ctrl_reg);
        end
        idle(2);
    endtask

`ifdef OPDEC_ERRCNT_EN
    task automatic test_errcnt();
        send_frame(40'h12_00000000, 1'b1);
        idle(1);
        n_checks++;
        if (err_count !== 8'h01) begin
            n_errors++;
            $display("FAIL errcnt_first got %h exp 01", err_count);
        end
        for (int i = 0; i < 253; i++) send_frame(40'hC7_00000000, 1'b0);
        idle(1);
        n_checks++;
        if (err_count !== 8'hFE) begin
            n_errors++;
            $display("FAIL errcnt_fe got %h exp fe", err_count);
        end
        for (int i = 0; i < 46; i++) send_frame(40'hC7_00000000, 1'b0);
        idle(2);
        n_checks++;
        if (err_count !== 8'hFF) begin
            n_errors++;
            $display("FAIL errcnt_sat got %h exp ff", err_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_audio();
        test_ctrl_kbd();
        test_bad_stop();
        test_unknown();
        test_back_to_back();
        test_timeout();
        test_strobe_wins();
        test_reset_mid();
`ifdef OPDEC_ERRCNT_EN
        test_errcnt();
`endif
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
